arrhythmia_feature_loader: RTL and testbench

Upstream feeder for the arrhythmia decision-tree classifier. Accepts one ECG sample as a serial stream of 8-bit feature bytes over a valid/ready handshake and picks out the five features the tree consumes (indices 13, 27, 235, 264, 278). It presents them as stable registered buses with an `out_valid`/`out_ready` handshake, so the combinational tree sees a clean, held feature vector. It also detects malformed sample lengths.

---
 rtl/arrhythmia_feature_loader.sv | 140 ++++++++++++++
 tb/tb_arrhythmia_feature_loader.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/arrhythmia_feature_loader.sv
// Serial feature-byte loader for the arrhythmia decision tree: captures five feature bytes per sample.
// Optional statistics counters are built when FEAT_LOADER_STATS_EN is defined.
module arrhythmia_feature_loader #(
  parameter int NUM_FEATURES = 279,
  parameter int IDX0 = 13,
  parameter int IDX1 = 27,
  parameter int IDX2 = 235,
  parameter int IDX3 = 264,
  parameter int IDX4 = 278
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  X13,
  output logic [7:0]  X27,
  output logic [7:0]  X235,
  output logic [7:0]  X264,
  output logic [7:0]  X278,
  output logic        len_err,
  output logic [15:0] sample_cnt,
  output logic [7:0]  err_cnt
);

  localparam logic [1:0] COLLECT = 2'd0;
  localparam logic [1:0] HOLD    = 2'd1;
  localparam logic [1:0] DRAIN   = 2'd2;

  localparam logic [8:0] LAST_IDX = 9'(NUM_FEATURES - 1);
  localparam logic [4:0][8:0] SEL = {9'(IDX4), 9'(IDX3), 9'(IDX2), 9'(IDX1), 9'(IDX0)};

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic [8:0]      idx;
  logic [4:0][7:0] shadow;
  logic [4:0][7:0] sh_nxt;
  logic            accept;
  logic            good;
  logic            bad;

  // Next-state decode; the current byte is folded into sh_nxt so a final byte that
  // is itself a selected feature reaches X* on the same edge.
  always_comb begin
    accept    = in_valid && in_ready;
    state_nxt = state;
    good      = 1'b0;
    bad       = 1'b0;
    sh_nxt    = shadow;
    for (int k = 0; k < 5; k++) begin
      if (state == COLLECT && accept && idx == SEL[k]) begin
        sh_nxt[k] = in_data;
      end else begin
        sh_nxt[k] = shadow[k];
      end
    end
    case (state)
      COLLECT: begin
        if (accept && in_last && idx == LAST_IDX) begin
          good      = 1'b1;
          state_nxt = HOLD;
        end else if (accept && in_last) begin
          bad       = 1'b1;
        end else if (accept && idx == LAST_IDX) begin
          bad       = 1'b1;
          state_nxt = DRAIN;
        end else begin
          state_nxt = COLLECT;
        end
      end
      HOLD: begin
        if (out_ready) state_nxt = COLLECT;
        else           state_nxt = HOLD;
      end
      DRAIN: begin
        if (accept && in_last) state_nxt = COLLECT;
        else                   state_nxt = DRAIN;
      end
      default: state_nxt = COLLECT;
    endcase
  end

  // Datapath and handshake registers; in_ready is registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= COLLECT;
      idx       <= 9'd0;
      shadow    <= '0;
      X13       <= 8'd0;
      X27       <= 8'd0;
      X235      <= 8'd0;
      X264      <= 8'd0;
      X278      <= 8'd0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
      len_err   <= 1'b0;
    end else begin
      state    <= state_nxt;
      shadow   <= sh_nxt;
      len_err  <= bad;
      in_ready <= (state_nxt != HOLD);
      if (good) begin
        X13       <= sh_nxt[0];
        X27       <= sh_nxt[1];
        X235      <= sh_nxt[2];
        X264      <= sh_nxt[3];
        X278      <= sh_nxt[4];
        out_valid <= 1'b1;
      end else if (state == HOLD && out_ready) begin
        out_valid <= 1'b0;
      end
      // idx stays frozen at LAST_IDX while draining an overlong sample
      if (accept && in_last && state != HOLD) begin
        idx <= 9'd0;
      end else if (accept && state == COLLECT && idx != LAST_IDX) begin
        idx <= idx + 9'd1;
      end
    end
  end

`ifdef FEAT_LOADER_STATS_EN
  // Saturating sample and error counters, updated on the same edge as out_valid/len_err.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sample_cnt <= 16'd0;
      err_cnt    <= 8'd0;
    end else begin
      if (good && sample_cnt != 16'hFFFF) sample_cnt <= sample_cnt + 16'd1;
      if (bad && err_cnt != 8'hFF)        err_cnt    <= err_cnt + 8'd1;
    end
  end
`else
  assign sample_cnt = 16'd0;
  assign err_cnt    = 8'd0;
`endif

endmodule

// File: tb/tb_arrhythmia_feature_loader.sv
// Directed self-checking bench for arrhythmia_feature_loader.
module tb_arrhythmia_feature_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  X13, X27, X235, X264, X278;
  logic        len_err;
  logic [15:0] sample_cnt;
  logic [7:0]  err_cnt;

  int vectors = 0;
  int fails   = 0;

  arrhythmia_feature_loader dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .X13(X13), .X27(X27), .X235(X235), .X264(X264), .X278(X278),
    .len_err(len_err), .sample_cnt(sample_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sends n bytes; byte i is i mod 256 or the fixed value; in_last on byte lastpos (-1: none)
  task automatic send(input int n, input int lastpos, input bit use_fixed, input logic [7:0] fixed);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = use_fixed ? fixed : 8'(i);
      in_last  = (i == lastpos);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_x(input string tag, input logic [7:0] e13, input logic [7:0] e27,
                         input logic [7:0] e235, input logic [7:0] e264, input logic [7:0] e278);
    check({tag, "_x13"},  {8'd0, X13},  {8'd0, e13});
    check({tag, "_x27"},  {8'd0, X27},  {8'd0, e27});
    check({tag, "_x235"}, {8'd0, X235}, {8'd0, e235});
    check({tag, "_x264"}, {8'd0, X264}, {8'd0, e264});
    check({tag, "_x278"}, {8'd0, X278}, {8'd0, e278});
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'd0; in_last = 1'b0; out_ready = 1'b1;
    tick();
    check("rst_in_ready", {15'd0, in_ready}, 16'd0);
    check("rst_out_valid", {15'd0, out_valid}, 16'd0);
    check("rst_len_err", {15'd0, len_err}, 16'd0);
    check_x("rst", 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    check("rst_sample_cnt", sample_cnt, 16'd0);
    check("rst_err_cnt", {8'd0, err_cnt}, 16'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", {15'd0, in_ready}, 16'd1);

    // Normal sample with out_ready tied high
    send(279, 278, 1'b0, 8'd0);
    check("norm_out_valid", {15'd0, out_valid}, 16'd1);
    check("norm_in_ready_low", {15'd0, in_ready}, 16'd0);
    check("norm_len_err", {15'd0, len_err}, 16'd0);
    check_x("norm", 8'd13, 8'd27, 8'd235, 8'd8, 8'd22);
    tick();
    check("norm_out_valid_drop", {15'd0, out_valid}, 16'd0);
    check("norm_in_ready_back", {15'd0, in_ready}, 16'd1);

    // Back-pressure, with junk input that must be ignored while holding
    out_ready = 1'b0;
    send(279, 278, 1'b1, 8'h3C);
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1; in_data = 8'h55; in_last = 1'b1;
      check("bp_in_ready", {15'd0, in_ready}, 16'd0);
      check("bp_out_valid", {15'd0, out_valid}, 16'd1);
      check("bp_x13", {8'd0, X13}, 16'h003C);
      check("bp_x278", {8'd0, X278}, 16'h003C);
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    tick();
    check("bp_release_out_valid", {15'd0, out_valid}, 16'd0);
    check("bp_release_in_ready", {15'd0, in_ready}, 16'd1);
    check("bp_release_len_err", {15'd0, len_err}, 16'd0);
    check_x("bp_release", 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C);

    // Short sample then a good all-AA sample
    send(100, 99, 1'b0, 8'd0);
    check("short_len_err", {15'd0, len_err}, 16'd1);
    check("short_out_valid", {15'd0, out_valid}, 16'd0);
    check("short_x13_kept", {8'd0, X13}, 16'h003C);
    tick();
    check("short_len_err_pulse", {15'd0, len_err}, 16'd0);
    send(279, 278, 1'b1, 8'hAA);
    check("aa_out_valid", {15'd0, out_valid}, 16'd1);
    check_x("aa", 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA);
    tick();

    // Long sample: 300 bytes, overrun flagged after byte 278, rest discarded
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'b1; in_data = 8'(i); in_last = (i == 299);
      tick();
      if (i == 277) check("long_no_err_early", {15'd0, len_err}, 16'd0);
      if (i == 278) check("long_len_err", {15'd0, len_err}, 16'd1);
      if (i == 279) check("long_len_err_pulse", {15'd0, len_err}, 16'd0);
      if (i == 290) check("long_drain_in_ready", {15'd0, in_ready}, 16'd1);
    end
    in_valid = 1'b0; in_last = 1'b0;
    check("long_out_valid", {15'd0, out_valid}, 16'd0);
    check("long_end_len_err", {15'd0, len_err}, 16'd0);
    check_x("long_kept", 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA);
    send(279, 278, 1'b0, 8'd0);
    check("after_long_out_valid", {15'd0, out_valid}, 16'd1);
    check_x("after_long", 8'd13, 8'd27, 8'd235, 8'd8, 8'd22);
    tick();
`ifdef FEAT_LOADER_STATS_EN
    check("stats_pre_rst_sample_cnt", sample_cnt, 16'd4);
    check("stats_pre_rst_err_cnt", {8'd0, err_cnt}, 16'd2);
`else
    check("nostats_sample_cnt", sample_cnt, 16'd0);
    check("nostats_err_cnt", {8'd0, err_cnt}, 16'd0);
`endif

    // Reset after byte 150 of a sample
    send(151, -1, 1'b0, 8'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_out_valid", {15'd0, out_valid}, 16'd0);
    check("midrst_in_ready", {15'd0, in_ready}, 16'd0);
    check_x("midrst", 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    check("midrst_sample_cnt", sample_cnt, 16'd0);
    tick();
    check("midrst_in_ready_back", {15'd0, in_ready}, 16'd1);
    send(279, 278, 1'b0, 8'd0);
    check("post_midrst_out_valid", {15'd0, out_valid}, 16'd1);
    check_x("post_midrst", 8'd13, 8'd27, 8'd235, 8'd8, 8'd22);
    tick();

    // Totals: 3 good and 2 short samples since reset
    send(279, 278, 1'b1, 8'h11);
    tick();
    send(50, 49, 1'b0, 8'd0);
    send(279, 278, 1'b1, 8'h22);
    check_x("third", 8'h22, 8'h22, 8'h22, 8'h22, 8'h22);
    tick();
    send(1, 0, 1'b0, 8'd0);
    check("one_byte_len_err", {15'd0, len_err}, 16'd1);
    tick();
`ifdef FEAT_LOADER_STATS_EN
    check("stats_sample_cnt", sample_cnt, 16'd3);
    check("stats_err_cnt", {8'd0, err_cnt}, 16'd2);
`else
    check("nostats_final_sample_cnt", sample_cnt, 16'd0);
    check("nostats_final_err_cnt", {8'd0, err_cnt}, 16'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
